mdu_iter: RTL and testbench

- Iterative multiply/divide unit beside the ALU in the CPU execute stage.
- Takes the same two 32-bit operands the ALU takes, selected by an op code.
- Runs multi-cycle radix-2 multiply or restoring divide and holds results in HI/LO registers.
- Drives busy/done so the controller can stall dependent instructions.

---
 rtl/mdu_iter.sv | 120 ++++++++++++
 tb/tb_mdu_iter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO result registers.
// Latency: WIDTH cycles from accept to HI/LO update; mthi/mtlo write on the accepting edge.
// Backpressure: start is ignored while busy; done pulses once per completed iterative op.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opb_q;
    logic                 is_div_q, neg_q_q, neg_r_q, done_q;

    logic                 a_neg, b_neg, last;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum, rem_sh, diff;
    logic [2*WIDTH-1:0]   mul_step, div_step, acc_step, prod;
    logic [WIDTH-1:0]     quo, rem;

    assign a_neg = ~md_op[0] & in1[WIDTH-1];
    assign b_neg = ~md_op[0] & in2[WIDTH-1];
    assign a_mag = a_neg ? -in1 : in1;
    assign b_mag = b_neg ? -in2 : in2;
    assign last  = (cnt_q == CW'(1));
    assign done  = done_q;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: if (start && !md_op[2]) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        mul_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, opb_q};
        div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
        acc_step = is_div_q ? div_step : mul_step;
        prod     = neg_q_q ? -acc_step : acc_step;
        quo      = neg_q_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem      = neg_r_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    case (md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            acc_q    <= {{WIDTH{1'b0}}, (md_op[1] ? a_mag : b_mag)};
                            opb_q    <= md_op[1] ? b_mag : a_mag;
                            is_div_q <= md_op[1];
                            // A zero divisor must leave the all-ones quotient unnegated.
                            neg_q_q  <= (a_neg ^ b_neg) & ~(md_op[1] & (in2 == '0));
                            neg_r_q  <= a_neg;
                            cnt_q    <= CW'(WIDTH);
                        end
                        3'b100:  hi <= in1;
                        3'b101:  lo <= in1;
                        default: ;
                    endcase
                end
            end else begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - CW'(1);
                if (last) begin
                    done_q <= 1'b1;
                    if (is_div_q) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter with a queue-based scoreboard.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mhi = '0, mlo = '0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] res;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        res = '0;
        case (op)
            3'd0: res = sa * sb;
            3'd1: res = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: pops expected results on done, checks busy length and HI/LO stability.
    initial begin
        bit pb, pd, stab;
        int bc;
        logic [63:0] e, h0;
        pb = 0; pd = 0; stab = 1; bc = 0; h0 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 0; pd = 0; bc = 0;
            end else begin
                if (pd) chk("done_pulse_width", 64'(done), 64'd0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {hi, lo}, e);
                    end
                end
                if (busy) begin
                    if (!pb) begin
                        bc = 0; h0 = {hi, lo}; stab = 1;
                    end
                    bc++;
                    if ({hi, lo} !== h0) stab = 0;
                end else if (pb) begin
                    chk("busy_len", 64'(bc), 64'd32);
                    chk("hilo_stable", 64'(stab), 64'd1);
                end
                pb = busy;
                pd = done;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        start = 1'b1; md_op = op; in1 = a; in2 = b;
        if (op < 3'd4) begin
            e = model(op, a, b);
            exp_q.push_back(e);
            mhi = e[63:32];
            mlo = e[31:0];
        end else if (op == 3'd4) mhi = a;
        else if (op == 3'd5) mlo = a;
        @(negedge clk);
        start = 1'b0; in1 = $urandom; in2 = $urandom;
        if (op < 3'd4) chk("accept_busy", 64'(busy), 64'd1);
        else begin
            chk("nonit_busy_done", 64'({busy, done}), 64'd0);
            chk("nonit_hilo", {hi, lo}, {mhi, mlo});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 200), 64'd1);
    endtask

    initial begin
        int n;
        logic [2:0] op;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({busy, done}), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        send(3'd1, 32'hFFFFFFFF, 32'h2); wait_idle();
        chk("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
        send(3'd0, 32'hFFFFFFFD, 32'h7); wait_idle();
        chk("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        send(3'd2, 32'hFFFFFFF9, 32'h2); wait_idle();
        chk("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        send(3'd3, 32'd100, 32'd7); wait_idle();
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        send(3'd3, 32'h12345678, 32'h0); wait_idle();
        chk("divu_zero", {hi, lo}, 64'h12345678_FFFFFFFF);
        send(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_idle();
        chk("div_ovf", {hi, lo}, 64'h00000000_80000000);

        // start mid-run must be ignored
        send(3'd3, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; md_op = 3'd0; in1 = 32'd5; in2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("midrun_ignored", {hi, lo}, {32'd1, 32'd333});
        repeat (3) @(negedge clk);
        chk("midrun_no_restart", 64'(busy), 64'd0);

        // back-to-back accept in the done cycle
        send(3'd1, 32'd3, 32'd5);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        send(3'd1, 32'd7, 32'd9); wait_idle();
        chk("b2b_result", {hi, lo}, 64'd63);

        send(3'd4, 32'hA5A5A5A5, 32'h0);
        chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        repeat (3) @(negedge clk);
        send(3'd5, 32'h0F0F0F0F, 32'h0);
        chk("mtlo_lo", 64'(lo), 64'h0F0F0F0F);

        // asynchronous reset mid-divide
        send(3'd2, 32'd12345, 32'd77);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 64'({busy, done}), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        exp_q.delete();
        mhi = '0; mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_arst_hilo", {hi, lo}, 64'd0);
        chk("post_arst_busy", 64'(busy), 64'd0);

        repeat (40) begin
            op = 3'($urandom_range(0, 7));
            a = rnd_val();
            b = rnd_val();
            send(op, a, b);
            if (op < 3'd4) wait_idle();
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
